// File: rtl/cpu_pkg.sv
// Shared constants for the fetch stage: reset PC, exception vectors,
// IF/ID bubble values and the redirect FSM encoding.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC     = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC    = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC     = 32'h8000_0008;

    localparam logic [31:0] BUBBLE_INSTR = NOP_INSTR;
    localparam logic [31:0] BUBBLE_PC4   = 32'h0000_0000;
    localparam logic        BUBBLE_VALID = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } fetch_state_e;

    // Fetch addresses are word aligned; low bits of any target are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux:
// exception > branch > jump > pending redirect > PC+4.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic        exc_valid,
    input  logic        exc_sel,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        pc_wr,
    input  logic        pend,
    input  logic [31:0] pend_target,
    input  logic [31:0] pc,
    output logic [31:0] redir_target,
    output logic [31:0] next_pc,
    output logic        pc_load
);

    // Branch comes from EX and is older than an ID jump, so it wins.
    always_comb begin
        redir_target = branch_taken ? word_align(branch_target)
                                    : word_align(jump_target);
    end

    // Select the next PC and whether the PC register loads this edge.
    always_comb begin
        next_pc = pc + 32'd4;
        pc_load = pc_wr;
        if (exc_valid) begin
            next_pc = exc_sel ? XADR_VEC : ILLOP_VEC;
            pc_load = 1'b1;
        end else if (branch_taken || jump_valid) begin
            next_pc = redir_target;
            pc_load = pc_wr;
        end else if (pend) begin
            next_pc = pend_target;
            pc_load = pc_wr;
        end
    end

endmodule

// File: rtl/if_stage_ctrl.sv
// Fetch stage control: PC register, IF/ID register and the buffered
// redirect FSM that holds a redirect until the PC is unstalled.
module if_stage_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWr,
    input  logic        IF_ID_Wr,
    input  logic        exc_valid,
    input  logic        exc_sel,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic [31:0] Instruction_in,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC_Plus4,
    output logic        IF_ID_Valid,
    output logic        redirect_pending
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic         ifid_valid_q, ifid_valid_d;

    logic [31:0]  redir_target;
    logic [31:0]  next_pc;
    logic         pc_load;
    logic         redirect;

    assign redirect = branch_taken | jump_valid;

    pc_next_sel u_pc_next_sel (
        .exc_valid     (exc_valid),
        .exc_sel       (exc_sel),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .pc_wr         (PCWr),
        .pend          (state_q == PEND),
        .pend_target   (pend_target_q),
        .pc            (pc_q),
        .redir_target  (redir_target),
        .next_pc       (next_pc),
        .pc_load       (pc_load)
    );

    // State register plus all datapath flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'h0;
            ifid_instr_q  <= BUBBLE_INSTR;
            ifid_pc4_q    <= BUBBLE_PC4;
            ifid_valid_q  <= BUBBLE_VALID;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_valid_q  <= ifid_valid_d;
        end
    end

    // Next state: a redirect seen during a stall parks the FSM in PEND.
    always_comb begin
        state_d = state_q;
        if (exc_valid) begin
            state_d = IDLE;
        end else if (redirect) begin
            state_d = PCWr ? IDLE : PEND;
        end else if (state_q == PEND && PCWr) begin
            state_d = IDLE;
        end
    end

    // Outputs: PC, buffered target and IF/ID contents.
    always_comb begin
        pc_d          = pc_load ? next_pc : pc_q;
        pend_target_d = pend_target_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_valid_d  = ifid_valid_q;
        if (!exc_valid && redirect && !PCWr) begin
            pend_target_d = redir_target;
        end
        if (exc_valid || redirect || state_q == PEND) begin
            ifid_instr_d = BUBBLE_INSTR;
            ifid_pc4_d   = BUBBLE_PC4;
            ifid_valid_d = BUBBLE_VALID;
        end else if (IF_ID_Wr) begin
            ifid_instr_d = Instruction_in;
            ifid_pc4_d   = pc_q + 32'd4;
            ifid_valid_d = 1'b1;
        end
    end

    assign PC                = pc_q;
    assign IF_ID_Instruction = ifid_instr_q;
    assign IF_ID_PC_Plus4    = ifid_pc4_q;
    assign IF_ID_Valid       = ifid_valid_q;
    assign redirect_pending  = (state_q == PEND);

endmodule
